// File: rtl/stream_src_ctrl.sv
// Source-selection controller: one of NUM_CH producers feeds the CDC buffer write side,
// with backpressure, stop-and-drain and a drain watchdog. Optional HOT_SWITCH_EN adds channel switching via drain.
module stream_src_ctrl #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DRAIN_TO = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        start,
  input  logic                     stop,
  input  logic                     buf_full,
  input  logic                     buf_empty,
  input  logic                     rd_valid,
  input  logic [NUM_CH-1:0]        src_valid,
  input  logic [NUM_CH*DATA_W-1:0] src_data,
  output logic [NUM_CH-1:0]        src_en,
  output logic                     wr_en,
  output logic [DATA_W-1:0]        wr_data,
  output logic [SEL_W-1:0]         active_ch,
  output logic [NUM_CH-1:0]        mode,
  output logic [1:0]               state,
  output logic                     err_multi,
  output logic                     err_drain_to
);

  localparam int unsigned CNT_W = (DRAIN_TO > 2) ? $clog2(DRAIN_TO) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             st_q;
  logic [CNT_W-1:0]   drain_cnt;
  logic [SEL_W-1:0]   start_idx;
  logic               start_one;
  logic               start_many;
  logic [NUM_CH-1:0]  act_onehot;
  logic [DATA_W-1:0]  act_data;
  logic               wr_take;
  logic               drain_last;
  logic               drain_done;

  // Start pulse decode: index of the (last) set bit and how many bits are set
  always_comb begin
    int unsigned n;
    n         = 0;
    start_idx = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (start[i]) begin
        start_idx = SEL_W'(i);
        n         = n + 1;
      end
    end
    start_one  = (n == 1);
    start_many = (n > 1);
  end

  assign act_onehot = NUM_CH'(1) << active_ch;
  assign act_data   = src_data[int'(active_ch)*int'(DATA_W) +: DATA_W];
  assign wr_take    = src_en[active_ch] & src_valid[active_ch] & ~buf_full & (st_q == S_RUN);
  assign drain_last = (DRAIN_TO != 0) && (drain_cnt == CNT_W'(DRAIN_TO - 1));
  assign drain_done = buf_empty & ~rd_valid;
  assign state      = st_q;

`ifdef HOT_SWITCH_EN
  logic             pend_valid;
  logic [SEL_W-1:0] pend_ch;
  logic             hot_req;
  assign hot_req = start_one && (start_idx != active_ch);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= S_IDLE;
      active_ch    <= '0;
      src_en       <= '0;
      mode         <= '0;
      wr_en        <= 1'b0;
      wr_data      <= '0;
      err_multi    <= 1'b0;
      err_drain_to <= 1'b0;
      drain_cnt    <= '0;
`ifdef HOT_SWITCH_EN
      pend_valid   <= 1'b0;
      pend_ch      <= '0;
`endif
    end else begin
      // Output decode lags the state register by one cycle
      src_en       <= (st_q == S_RUN) ? act_onehot : '0;
      mode         <= (st_q == S_RUN || st_q == S_WAIT) ? act_onehot : '0;
      wr_en        <= wr_take;
      if (wr_take) wr_data <= act_data;
      err_multi    <= 1'b0;
      err_drain_to <= 1'b0;

      case (st_q)
        S_IDLE: begin
          if (start_one) begin
            active_ch <= start_idx;
            st_q      <= S_RUN;
          end else if (start_many) begin
            err_multi <= 1'b1;
          end
        end
        S_RUN, S_WAIT: begin
`ifdef HOT_SWITCH_EN
          if (start_many) err_multi <= 1'b1;
`endif
          if (stop) begin
            st_q      <= S_DRAIN;
            drain_cnt <= '0;
`ifdef HOT_SWITCH_EN
            pend_valid <= 1'b0;
          end else if (hot_req) begin
            st_q       <= S_DRAIN;
            drain_cnt  <= '0;
            pend_valid <= 1'b1;
            pend_ch    <= start_idx;
`endif
          end else if (st_q == S_RUN && buf_full) begin
            st_q <= S_WAIT;
          end else if (st_q == S_WAIT && !buf_full) begin
            st_q <= S_RUN;
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
`ifdef HOT_SWITCH_EN
            pend_valid <= 1'b0;
            if (pend_valid && !stop) begin
              st_q      <= S_RUN;
              active_ch <= pend_ch;
            end else begin
              st_q <= S_IDLE;
            end
`else
            st_q <= S_IDLE;
`endif
          end else if (drain_last) begin
            st_q         <= S_IDLE;
            err_drain_to <= 1'b1;
`ifdef HOT_SWITCH_EN
            pend_valid   <= 1'b0;
`endif
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
`ifdef HOT_SWITCH_EN
            if (stop) pend_valid <= 1'b0;
`endif
          end
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_src_ctrl.sv
// Self-checking bench for stream_src_ctrl: vector table, corner sequences, randomized run vs reference model.
module tb_stream_src_ctrl;

  localparam int MAIN_TO = 16;
`ifdef HOT_SWITCH_EN
  localparam bit HOT = 1'b1;
`else
  localparam bit HOT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0]  start = '0;
  logic        stop = 1'b0, buf_full = 1'b0, buf_empty = 1'b1, rd_valid = 1'b0;
  logic [3:0]  src_valid = '0;
  logic [63:0] src_data = '0;

  logic [3:0]  src_en, mode, w_src_en, w_mode;
  logic        wr_en, err_multi, err_drain_to, w_wr_en, w_err_multi, w_err_drain_to;
  logic [15:0] wr_data, w_wr_data;
  logic [1:0]  active_ch, state, w_active_ch, w_state;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  stream_src_ctrl #(.NUM_CH(4), .SEL_W(2), .DATA_W(16), .DRAIN_TO(MAIN_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .buf_full(buf_full),
    .buf_empty(buf_empty), .rd_valid(rd_valid), .src_valid(src_valid), .src_data(src_data),
    .src_en(src_en), .wr_en(wr_en), .wr_data(wr_data), .active_ch(active_ch), .mode(mode),
    .state(state), .err_multi(err_multi), .err_drain_to(err_drain_to));

  stream_src_ctrl #(.NUM_CH(4), .SEL_W(2), .DATA_W(16), .DRAIN_TO(8)) dut_wd (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .buf_full(buf_full),
    .buf_empty(buf_empty), .rd_valid(rd_valid), .src_valid(src_valid), .src_data(src_data),
    .src_en(w_src_en), .wr_en(w_wr_en), .wr_data(w_wr_data), .active_ch(w_active_ch), .mode(w_mode),
    .state(w_state), .err_multi(w_err_multi), .err_drain_to(w_err_drain_to));

  typedef struct {
    logic [3:0]  start;
    logic        stop, full, empty;
    logic [3:0]  sv;
    logic [1:0]  st, ch;
    logic [3:0]  en, md;
    logic        wr;
    logic [15:0] wd;
    logic        em;
  } vec_t;

  vec_t tbl[12];

  // Reference model state (spec-level quantities)
  int          m_st, m_ch, m_cnt, m_pc;
  bit          m_pv;
  logic [3:0]  m_en, m_mode;
  logic        m_wr, m_em, m_et;
  logic [15:0] m_wd;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = '0; stop = 1'b0; buf_full = 1'b0; buf_empty = 1'b1; rd_valid = 1'b0; src_valid = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_st = 0; m_ch = 0; m_cnt = 0; m_pc = 0; m_pv = 0;
    m_en = '0; m_mode = '0; m_wr = 0; m_em = 0; m_et = 0; m_wd = '0;
  endtask

  task automatic model_step();
    int pop, idx, n_st, n_ch, n_cnt, n_pc;
    bit n_pv, hot;
    logic [3:0] n_en, n_mode;
    logic n_wr, n_em, n_et;
    logic [15:0] n_wd;
    pop = $countones(start);
    idx = 0;
    for (int i = 0; i < 4; i++) if (start[i]) idx = i;
    n_en   = (m_st == 1) ? 4'(1 << m_ch) : 4'd0;
    n_mode = (m_st == 1 || m_st == 2) ? 4'(1 << m_ch) : 4'd0;
    n_wr   = m_en[m_ch] && src_valid[m_ch] && !buf_full && (m_st == 1);
    n_wd   = n_wr ? src_data[m_ch*16 +: 16] : m_wd;
    n_em = 0; n_et = 0;
    n_st = m_st; n_ch = m_ch; n_cnt = m_cnt; n_pv = m_pv; n_pc = m_pc;
    hot = HOT && pop == 1 && idx != m_ch;
    case (m_st)
      0: begin
        if (pop == 1) begin n_st = 1; n_ch = idx; end
        else if (pop > 1) n_em = 1;
      end
      1, 2: begin
        if (HOT && pop > 1) n_em = 1;
        if (stop) begin n_st = 3; n_cnt = 0; n_pv = 0; end
        else if (hot) begin n_st = 3; n_cnt = 0; n_pv = 1; n_pc = idx; end
        else if (m_st == 1 && buf_full) n_st = 2;
        else if (m_st == 2 && !buf_full) n_st = 1;
      end
      default: begin
        if (buf_empty && !rd_valid) begin
          if (m_pv && !stop) begin n_st = 1; n_ch = m_pc; end
          else n_st = 0;
          n_pv = 0;
        end else if (m_cnt == MAIN_TO - 1) begin
          n_st = 0; n_et = 1; n_pv = 0;
        end else begin
          n_cnt = m_cnt + 1;
          if (stop) n_pv = 0;
        end
      end
    endcase
    m_st = n_st; m_ch = n_ch; m_cnt = n_cnt; m_pv = n_pv; m_pc = n_pc;
    m_en = n_en; m_mode = n_mode; m_wr = n_wr; m_wd = n_wd; m_em = n_em; m_et = n_et;
  endtask

  initial begin
    int first_idle, pulses;
    bit saw_idle;

    tbl[0]  = '{4'b0011, 0, 0, 1, 4'b0000, 2'd0, 2'd0, 4'b0000, 4'b0000, 0, 16'h0000, 1};
    tbl[1]  = '{4'b0000, 0, 0, 1, 4'b0000, 2'd0, 2'd0, 4'b0000, 4'b0000, 0, 16'h0000, 0};
    tbl[2]  = '{4'b0100, 0, 0, 1, 4'b0000, 2'd1, 2'd2, 4'b0000, 4'b0000, 0, 16'h0000, 0};
    tbl[3]  = '{4'b0000, 0, 0, 1, 4'b0100, 2'd1, 2'd2, 4'b0100, 4'b0100, 0, 16'h0000, 0};
    tbl[4]  = '{4'b0000, 0, 0, 1, 4'b0100, 2'd1, 2'd2, 4'b0100, 4'b0100, 1, 16'h00AB, 0};
    tbl[5]  = '{4'b0000, 0, 1, 1, 4'b0100, 2'd2, 2'd2, 4'b0100, 4'b0100, 0, 16'h00AB, 0};
    tbl[6]  = '{4'b0000, 0, 1, 1, 4'b0000, 2'd2, 2'd2, 4'b0000, 4'b0100, 0, 16'h00AB, 0};
    tbl[7]  = '{4'b0000, 0, 0, 1, 4'b0100, 2'd1, 2'd2, 4'b0000, 4'b0100, 0, 16'h00AB, 0};
    tbl[8]  = '{4'b0000, 0, 0, 1, 4'b0100, 2'd1, 2'd2, 4'b0100, 4'b0100, 0, 16'h00AB, 0};
    tbl[9]  = '{4'b0000, 0, 0, 1, 4'b0100, 2'd1, 2'd2, 4'b0100, 4'b0100, 1, 16'h00AB, 0};
    tbl[10] = '{4'b0000, 1, 1, 1, 4'b0100, 2'd3, 2'd2, 4'b0100, 4'b0100, 0, 16'h00AB, 0};
    tbl[11] = '{4'b0000, 0, 0, 0, 4'b0000, 2'd3, 2'd2, 4'b0000, 4'b0000, 0, 16'h00AB, 0};

    // Reset state
    do_reset();
    check("reset", {state, active_ch, src_en, mode, wr_en, wr_data, err_multi, err_drain_to}, '0);

    // Vector table: multi-start error, start/run, write path, backpressure, stop beats buf_full
    src_data = {16'h0D0D, 16'h00AB, 16'h0101, 16'h0E0E};
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; buf_full = tbl[i].full;
      buf_empty = tbl[i].empty; src_valid = tbl[i].sv; rd_valid = 1'b0;
      tick();
      check($sformatf("vec%0d", i),
            {state, active_ch, src_en, mode, wr_en, wr_data, err_multi},
            {tbl[i].st, tbl[i].ch, tbl[i].en, tbl[i].md, tbl[i].wr, tbl[i].wd, tbl[i].em});
    end

    // Drain held by non-empty buffer, then by rd_valid, then completes
    idle_inputs();
    buf_empty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("drain_hold", {state, mode}, {2'd3, 4'b0000});
    end
    buf_empty = 1'b1; rd_valid = 1'b1;
    tick();
    check("drain_rd_valid", state, 2'd3);
    rd_valid = 1'b0;
    tick();
    check("drain_done", {state, active_ch}, {2'd0, 2'd2});

    // Asynchronous reset aborts a drain immediately
    start = 4'b0001;
    tick();
    start = '0; stop = 1'b1;
    tick();
    stop = 1'b0; buf_empty = 1'b0;
    tick();
    check("pre_abort", state, 2'd3);
    rst = 1'b1;
    #1;
    check("async_abort", {state, active_ch, src_en, mode}, '0);
    do_reset();

    // Drain watchdog on the DRAIN_TO=8 instance
    start = 4'b0001;
    tick();
    start = '0; stop = 1'b1;
    tick();
    check("wd_entry", w_state, 2'd3);
    stop = 1'b0; buf_empty = 1'b0;
    first_idle = -1; pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (w_err_drain_to) pulses++;
      if (w_state == 2'd0 && first_idle < 0) first_idle = k;
    end
    check("wd_cycles", 64'(first_idle), 64'd8);
    check("wd_pulses", 64'(pulses), 64'd1);
    do_reset();

    // Hot switch request from a running channel
    start = 4'b0010;
    tick();
    start = '0;
    tick();
    tick();
    check("hs_run", {state, active_ch}, {2'd1, 2'd1});
    start = 4'b1000; buf_empty = 1'b0;
    tick();
    start = '0;
    saw_idle = (state == 2'd0);
    if (HOT) check("hs_drain", state, 2'd3);
    else     check("hs_ignored", {state, active_ch}, {2'd1, 2'd1});
    buf_empty = 1'b1; rd_valid = 1'b0;
    tick();
    saw_idle = saw_idle || (state == 2'd0);
    if (HOT) check("hs_switch", {state, active_ch, saw_idle}, {2'd1, 2'd3, 1'b0});
    else     check("hs_stays", {state, active_ch}, {2'd1, 2'd1});

    // Randomized run against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      stop      = ($urandom_range(0, 19) == 0);
      buf_full  = ($urandom_range(0, 3) == 0);
      buf_empty = ($urandom_range(0, 3) == 0);
      rd_valid  = ($urandom_range(0, 1) == 0);
      src_valid = 4'($urandom);
      src_data  = {$urandom, $urandom};
      model_step();
      tick();
      check($sformatf("rand%0d", c),
            {state, active_ch, src_en, mode, wr_en, wr_data, err_multi, err_drain_to},
            {2'(m_st), 2'(m_ch), m_en, m_mode, m_wr, m_wd, m_em, m_et});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
